// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared core types and top-level defaults for the issue queue
package ariane_pkg;

  localparam int unsigned ID_QUEUE_DEPTH  = 4;
  localparam int unsigned ID_QUEUE_MAX_CF = 1;

  typedef enum logic [3:0] {
    FU_NONE,
    FU_LOAD,
    FU_STORE,
    FU_ALU,
    FU_CTRL_FLOW,
    FU_MULT,
    FU_CSR
  } fu_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [7:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
  } scoreboard_entry_t;

  // One queue slot: the instruction plus its control-flow marker.
  typedef struct packed {
    scoreboard_entry_t instr;
    logic              cf;
  } id_queue_entry_t;

endpackage

// File: rtl/id_issue_queue.sv
// rtl/id_issue_queue.sv - in-order decode-to-issue queue with control-flow limit; optional ID_ISSUE_QUEUE_BYPASS_EN
module id_issue_queue
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH  = ID_QUEUE_DEPTH,
  parameter int unsigned MAX_CF = ID_QUEUE_MAX_CF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  scoreboard_entry_t          decoded_instr_i,
  input  logic                       decoded_instr_valid_i,
  input  logic                       is_ctrl_flow_i,
  output logic                       decoded_instr_ack_o,
  output scoreboard_entry_t          issue_instr_o,
  output logic                       issue_instr_valid_o,
  output logic                       issue_is_ctrl_flow_o,
  input  logic                       issue_ack_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     usage_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(MAX_CF + 1);

  id_queue_entry_t mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW:0]     cnt_q, cnt_d;
  logic [CW-1:0]   cf_cnt_q, cf_cnt_d;

  logic full, empty, cf_at_limit, stored_valid, bypass, push, pop;

  assign full        = (cnt_q == (PW+1)'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign cf_at_limit = (cf_cnt_q == CW'(MAX_CF));

  // Acceptance never looks at the issue side, so there is no pop-through when full.
  assign decoded_instr_ack_o = !rst_i && !flush_i && !full && !(is_ctrl_flow_i && cf_at_limit);
  assign stored_valid        = !empty && !flush_i;

`ifdef ID_ISSUE_QUEUE_BYPASS_EN
  assign bypass = empty && decoded_instr_valid_i && decoded_instr_ack_o;
`else
  assign bypass = 1'b0;
`endif

  assign issue_instr_valid_o  = stored_valid || bypass;
  assign issue_instr_o        = bypass ? decoded_instr_i : mem_q[rd_ptr_q].instr;
  assign issue_is_ctrl_flow_o = bypass ? is_ctrl_flow_i  : mem_q[rd_ptr_q].cf;

  // A bypassed instruction consumed in the same cycle never touches storage.
  assign pop  = issue_ack_i && stored_valid;
  assign push = decoded_instr_valid_i && decoded_instr_ack_o && !(bypass && issue_ack_i);

  assign full_o  = full;
  assign empty_o = empty;
  assign usage_o = cnt_q;

  // Next-state for pointers and counters; flush wins over any handshake.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    cf_cnt_d = cf_cnt_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      cf_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + (PW+1)'(1);
        2'b01:   cnt_d = cnt_q - (PW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
      case ({push && is_ctrl_flow_i, pop && mem_q[rd_ptr_q].cf})
        2'b10:   cf_cnt_d = cf_cnt_q + CW'(1);
        2'b01:   cf_cnt_d = cf_cnt_q - CW'(1);
        default: cf_cnt_d = cf_cnt_q;
      endcase
    end
  end

  // State and storage registers; reset clears storage so the head reads as zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      cf_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      cf_cnt_q <= cf_cnt_d;
      if (push) begin
        mem_q[wr_ptr_q].instr <= decoded_instr_i;
        mem_q[wr_ptr_q].cf    <= is_ctrl_flow_i;
      end
    end
  end

endmodule
